// File: rtl/bus_periph_fabric_if.sv
// CPU-side request/response bus of the peripheral fabric.
// The CPU (master) issues one-cycle strobes; the fabric (slave) returns a one-cycle ready pulse.
interface bus_periph_fabric_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          i_bus_stb;
  logic          i_bus_we;
  logic [AW-1:0] i_bus_addr;
  logic [DW-1:0] i_bus_wr_data;
  logic [DW-1:0] o_bus_rd_data;
  logic          o_bus_rd_ready;
  logic          o_bus_err;
  logic          o_bus_busy;

  modport master (
    output i_bus_stb, i_bus_we, i_bus_addr, i_bus_wr_data,
    input  o_bus_rd_data, o_bus_rd_ready, o_bus_err, o_bus_busy
  );

  modport slave (
    input  i_bus_stb, i_bus_we, i_bus_addr, i_bus_wr_data,
    output o_bus_rd_data, o_bus_rd_ready, o_bus_err, o_bus_busy
  );

endinterface

// File: rtl/bus_periph_fabric.sv
// Address-decoding peripheral fabric: base/mask decode, one-hot select, single-cycle strobe,
// registered response with decode-miss and timeout errors.
module bus_periph_fabric #(
  parameter int                    NPERIPH = 4,
  parameter int                    AW      = 32,
  parameter int                    DW      = 32,
  parameter logic [NPERIPH*AW-1:0] BASE    = {NPERIPH{32'h0}},
  parameter logic [NPERIPH*AW-1:0] MASK    = {NPERIPH{32'hFFFF_FFFF}},
  parameter int                    TIMEOUT = 255
) (
  input  logic                  clk_100mhz,
  input  logic                  rstn_i,
  bus_periph_fabric_if.slave    bus,
  output logic [NPERIPH-1:0]    o_periph_cs,
  output logic [NPERIPH-1:0]    o_periph_stb,
  output logic                  o_periph_we,
  output logic [AW-1:0]         o_periph_addr,
  output logic [DW-1:0]         o_periph_wr_data,
  input  logic [NPERIPH*DW-1:0] i_periph_rd_data,
  input  logic [NPERIPH-1:0]    i_periph_ready,
  output logic [7:0]            o_err_count
);

  localparam int IW = (NPERIPH > 1) ? $clog2(NPERIPH) : 1;
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [CW-1:0] tmo_cnt;
  logic          miss;

  logic          hit_any;
  logic [IW-1:0] hit_idx;
  logic          ready_sel;
  logic [DW-1:0] rd_sel;

  // Scan from the top down so the lowest-index hit overwrites the rest.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NPERIPH - 1; i >= 0; i--) begin
      if ((bus.i_bus_addr & MASK[i*AW +: AW]) == (BASE[i*AW +: AW] & MASK[i*AW +: AW])) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign ready_sel = i_periph_ready[idx];
  assign rd_sel    = i_periph_rd_data[idx*DW +: DW];

  // A decode miss spends one cycle in WAIT with no select, so misses and zero-wait hits
  // answer on the same edge and share the same three-cycle request spacing.
  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      state              <= IDLE;
      idx                <= '0;
      tmo_cnt            <= '0;
      miss               <= 1'b0;
      o_periph_cs        <= '0;
      o_periph_stb       <= '0;
      o_periph_we        <= 1'b0;
      o_periph_addr      <= '0;
      o_periph_wr_data   <= '0;
      o_err_count        <= '0;
      bus.o_bus_rd_data  <= '0;
      bus.o_bus_rd_ready <= 1'b0;
      bus.o_bus_err      <= 1'b0;
      bus.o_bus_busy     <= 1'b0;
    end else begin
      o_periph_stb       <= '0;
      bus.o_bus_rd_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_bus_stb) begin
            o_periph_we      <= bus.i_bus_we;
            o_periph_addr    <= bus.i_bus_addr;
            o_periph_wr_data <= bus.i_bus_wr_data;
            idx              <= hit_idx;
            miss             <= !hit_any;
            tmo_cnt          <= '0;
            bus.o_bus_busy   <= 1'b1;
            state            <= WAIT;
            if (hit_any) begin
              o_periph_cs  <= NPERIPH'(1) << hit_idx;
              o_periph_stb <= NPERIPH'(1) << hit_idx;
            end
          end
        end
        WAIT: begin
          if (!miss && ready_sel) begin
            bus.o_bus_rd_data  <= o_periph_we ? '0 : rd_sel;
            bus.o_bus_err      <= 1'b0;
            bus.o_bus_rd_ready <= 1'b1;
            state              <= RESP;
          end else if (miss || (TIMEOUT != 0 && tmo_cnt == CW'(TIMEOUT))) begin
            bus.o_bus_rd_data  <= '0;
            bus.o_bus_err      <= 1'b1;
            bus.o_bus_rd_ready <= 1'b1;
            if (o_err_count != 8'hFF) begin
              o_err_count <= o_err_count + 8'd1;
            end
            state              <= RESP;
          end else if (TIMEOUT != 0) begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        RESP: begin
          o_periph_cs    <= '0;
          bus.o_bus_busy <= 1'b0;
          state          <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
